// File: rtl/ram1_pkg.sv
// Shared types and constants for the RAM1 bus responder.
package ram1_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 18;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  // Wide enough to hold RD_LAT_MAX-1.
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_HOLD
  } state_t;

endpackage

// File: rtl/ram1_array.sv
// Word storage for ram1_responder: synchronous write, asynchronous read.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module ram1_array
  import ram1_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram1_responder.sv
// Responder for an asynchronous-style SRAM bus (active-low EN/OE/WE),
// re-timed onto clk. Reads return data RD_LAT cycles after the request
// sample; writes commit when WE is released.
// Ports: clk, rst (sync, active-low); Ram1Addr/Ram1Data/Ram1OE/Ram1WE/Ram1EN
// bus; light = last committed in-range write data; err = sticky error.
module ram1_responder
  import ram1_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Ram1Addr,
  inout  logic [DATA_W-1:0] Ram1Data,
  input  logic              Ram1OE,
  input  logic              Ram1WE,
  input  logic              Ram1EN,
  output logic [DATA_W-1:0] light,
  output logic              err
);

  // Out-of-range latencies are clamped to the supported window.
  localparam int unsigned LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cap_addr, cap_addr_nxt;
  logic [DATA_W-1:0] cap_data, cap_data_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] out_q, out_nxt;
  logic [DATA_W-1:0] light_nxt;
  logic              err_nxt;

  logic              wr_req, rd_req;
  logic              start_rd, load_out, commit;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rdata, rd_word;
  logic              drive;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> DEPTH_LOG2) == '0;
  endfunction

  assign wr_req = !Ram1EN && !Ram1WE;
  assign rd_req = !Ram1EN && !Ram1OE && Ram1WE;

  // While driving, follow the live address so a change shows up next cycle.
  assign rd_addr = (state == RD_DRIVE) ? Ram1Addr : cap_addr;
  assign rd_word = in_range(rd_addr) ? rdata : '0;

  ram1_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (cap_addr[DEPTH_LOG2-1:0]),
    .wdata (cap_data),
    .raddr (rd_addr[DEPTH_LOG2-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    state_nxt    = state;
    cap_addr_nxt = cap_addr;
    cap_data_nxt = cap_data;
    cnt_nxt      = cnt;
    out_nxt      = out_q;
    light_nxt    = light;
    err_nxt      = err;
    start_rd     = 1'b0;
    load_out     = 1'b0;
    commit       = 1'b0;

    case (state)
      IDLE: begin
        if (wr_req) begin
          state_nxt = WR_HOLD;
        end else if (rd_req) begin
          state_nxt = RD_WAIT;
          start_rd  = 1'b1;
        end
      end
      RD_WAIT: begin
        if (wr_req) begin
          state_nxt = WR_HOLD;
        end else if (!rd_req) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = RD_DRIVE;
          load_out  = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RD_DRIVE: begin
        if (wr_req) begin
          state_nxt = WR_HOLD;
        end else if (!rd_req) begin
          state_nxt = IDLE;
        end else begin
          load_out     = 1'b1;
          cap_addr_nxt = Ram1Addr;
          if (!in_range(Ram1Addr)) begin
            err_nxt = 1'b1;
          end
        end
      end
      WR_HOLD: begin
        if (!wr_req) begin
          commit = 1'b1;
          if (rd_req) begin
            state_nxt = RD_WAIT;
            start_rd  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Every state enters WR_HOLD on a write sample, so capture is shared.
    if (wr_req) begin
      cap_addr_nxt = Ram1Addr;
      cap_data_nxt = Ram1Data;
      if (!Ram1OE || !in_range(Ram1Addr)) begin
        err_nxt = 1'b1;
      end
    end

    if (start_rd) begin
      cap_addr_nxt = Ram1Addr;
      cnt_nxt      = CNT_W'(LAT - 1);
      if (!in_range(Ram1Addr)) begin
        err_nxt = 1'b1;
      end
    end

    if (load_out) begin
      out_nxt = rd_word;
    end

    if (commit && in_range(cap_addr)) begin
      light_nxt = cap_data;
    end
  end

  // Gated by rst so a write pending at reset is discarded.
  assign wr_en = rst && commit && in_range(cap_addr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cap_addr <= '0;
      cap_data <= '0;
      cnt      <= '0;
      out_q    <= '0;
      light    <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cap_addr <= cap_addr_nxt;
      cap_data <= cap_data_nxt;
      cnt      <= cnt_nxt;
      out_q    <= out_nxt;
      light    <= light_nxt;
      err      <= err_nxt;
    end
  end

  assign drive    = (state == RD_DRIVE) && !Ram1EN && !Ram1OE && Ram1WE;
  assign Ram1Data = drive ? out_q : 'z;

endmodule

// File: tb/tb_ram1_responder.sv
// Bench for ram1_responder (DEPTH_LOG2=10, RD_LAT=2).
module tb_ram1_responder;

  localparam int unsigned LAT = 2;
  localparam int M_NONE = 0;
  localparam int M_Z    = 1;
  localparam int M_DRV  = 2;

  logic        clk;
  logic        rst;
  logic [17:0] addr;
  logic        oe, we, en;
  logic [15:0] light;
  logic        err;
  logic [15:0] tb_data;
  logic        tb_drv;
  wire  [15:0] bus;

  int          total;
  int          bad;
  int          mon_mode;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  assign bus = tb_drv ? tb_data : 16'hzzzz;

  ram1_responder #(
    .DEPTH_LOG2(10),
    .RD_LAT    (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Ram1Addr (addr),
    .Ram1Data (bus),
    .Ram1OE   (oe),
    .Ram1WE   (we),
    .Ram1EN   (en),
    .light    (light),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  // Monitor: checks the bus in the middle of each cycle.
  always @(negedge clk) begin
    if (mon_mode == M_Z) begin
      total += 1;
      if (bus !== 16'hzzzz) begin
        bad += 1;
        $display("FAIL bus_z: got %h want zzzz", bus);
      end
    end else if (mon_mode == M_DRV) begin
      total += 1;
      if (exp_q.size() == 0) begin
        bad += 1;
        $display("FAIL rd_data: got %h want <nothing queued>", bus);
      end else begin
        e = exp_q.pop_front();
        if ((bus === 16'hzzzz) || (bus !== e)) begin
          bad += 1;
          $display("FAIL rd_data: got %h want %h", bus, e);
        end
      end
    end
  end

  task automatic step(input logic en_n, input logic oe_n, input logic we_n,
                      input logic [17:0] a, input logic [15:0] d, input int m);
    en       = en_n;
    oe       = oe_n;
    we       = we_n;
    addr     = a;
    tb_data  = d;
    tb_drv   = !we_n;
    mon_mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int m);
    step(1'b1, 1'b1, 1'b1, '0, '0, m);
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d);
    step(1'b0, 1'b1, 1'b0, a, d, M_NONE);
    idle(M_Z);
  endtask

  task automatic rd(input logic [17:0] a, input int n, input logic [15:0] x);
    for (int i = 0; i < int'(LAT) + 1; i++) step(1'b0, 1'b0, 1'b1, a, '0, M_Z);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(x);
      step(1'b0, 1'b0, 1'b1, a, '0, M_DRV);
    end
    step(1'b0, 1'b1, 1'b1, a, '0, M_Z);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    total += 1;
    if (act !== want) begin
      bad += 1;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    mon_mode = M_NONE;
    rst      = 1'b0;
    for (int i = 0; i < 3; i++) idle(M_NONE);
    rst = 1'b1;
    chk("reset_light", light, 16'h0000);
    chk("reset_err", {15'd0, err}, 16'h0000);
    idle(M_Z);

    // Write 0x1234 to 5, WE low for two cycles.
    step(1'b0, 1'b1, 1'b0, 18'd5, 16'h1234, M_NONE);
    step(1'b0, 1'b1, 1'b0, 18'd5, 16'h1234, M_NONE);
    chk("light_before_commit", light, 16'h0000);
    idle(M_Z);
    chk("light_commit_5", light, 16'h1234);
    chk("err_after_write", {15'd0, err}, 16'h0000);

    // Read 5: two Z cycles, then data, Z as OE rises.
    rd(18'd5, 3, 16'h1234);

    // Write 7 with data changing while WE low: last sample wins.
    step(1'b0, 1'b1, 1'b0, 18'd7, 16'hAAAA, M_NONE);
    step(1'b0, 1'b1, 1'b0, 18'd7, 16'h5555, M_NONE);
    idle(M_Z);
    chk("light_commit_7", light, 16'h5555);
    rd(18'd7, 2, 16'h5555);

    // Write 11 and read it on the very commit edge; then move to address 5.
    step(1'b0, 1'b1, 1'b0, 18'd11, 16'hBEEF, M_NONE);
    step(1'b0, 1'b0, 1'b1, 18'd11, '0, M_Z);
    chk("light_commit_11", light, 16'hBEEF);
    step(1'b0, 1'b0, 1'b1, 18'd11, '0, M_Z);
    step(1'b0, 1'b0, 1'b1, 18'd11, '0, M_Z);
    exp_q.push_back(16'hBEEF);
    step(1'b0, 1'b0, 1'b1, 18'd5, '0, M_DRV);
    exp_q.push_back(16'h1234);
    step(1'b0, 1'b0, 1'b1, 18'd5, '0, M_DRV);
    step(1'b0, 1'b1, 1'b1, 18'd5, '0, M_Z);
    chk("err_still_clear", {15'd0, err}, 16'h0000);

    wr(18'd9, 16'h0909);
    chk("light_commit_9", light, 16'h0909);

    // Out-of-range read and write.
    rd(18'h3FFFF, 2, 16'h0000);
    chk("err_oor_read", {15'd0, err}, 16'h0001);
    wr(18'h3FFFF, 16'hDEAD);
    chk("light_oor_write", light, 16'h0909);

    // Reset while a write to 9 is pending.
    step(1'b0, 1'b1, 1'b0, 18'd9, 16'h6666, M_NONE);
    rst = 1'b0;
    idle(M_Z);
    idle(M_Z);
    rst = 1'b1;
    idle(M_Z);
    chk("light_after_reset", light, 16'h0000);
    chk("err_after_reset", {15'd0, err}, 16'h0000);
    rd(18'd9, 2, 16'h0909);
    rd(18'd5, 1, 16'h1234);

    // OE and WE both low while enabled: treated as a write, flags err.
    step(1'b0, 1'b0, 1'b0, 18'd3, 16'h00FF, M_NONE);
    chk("err_oe_we_clash", {15'd0, err}, 16'h0001);
    idle(M_Z);
    chk("light_commit_3", light, 16'h00FF);
    rd(18'd3, 2, 16'h00FF);
    chk("err_sticky", {15'd0, err}, 16'h0001);

    idle(M_NONE);
    total += 1;
    if (exp_q.size() != 0) begin
      bad += 1;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram1_responder.md
RAM1_RESPONDER -- requirements
Module: ram1_responder

Interface
REQ-001 SHALL provide parameter DEPTH_LOG2, default 10, meaning log2 of the number of implemented 16-bit words.
REQ-002 SHALL provide parameter RD_LAT, default 1, meaning cycles from read-request sample to data drive; legal range 1..4.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL provide port Ram1Addr, input, 18 bits: word address from the initiator.
REQ-006 SHALL provide port Ram1Data, inout, 16 bits: write data in, read data out; high-Z when not driving.
REQ-007 SHALL provide port Ram1OE, input, 1 bit: output enable, active-low.
REQ-008 SHALL provide port Ram1WE, input, 1 bit: write enable, active-low.
REQ-009 SHALL provide port Ram1EN, input, 1 bit: chip enable, active-low.
REQ-010 SHALL provide port light, output, 16 bits: data of the most recent committed in-range write.
REQ-011 SHALL provide port err, output, 1 bit: sticky flag for protocol or range errors.

Function
REQ-012 SHALL sample Ram1EN/OE/WE/Addr/Data at every rising clk edge; a request is valid only when Ram1EN=0.
REQ-013 SHALL implement states IDLE, RD_WAIT, RD_DRIVE, WR_HOLD.
REQ-014 IDLE: EN=0, WE=0 -> capture addr/data, go WR_HOLD; EN=0, OE=0, WE=1 -> capture addr, load latency counter, go RD_WAIT; otherwise stay.
REQ-015 RD_WAIT: counter decrements each cycle; after RD_LAT cycles from the request sample, go RD_DRIVE with mem[addr] registered into the output data register.
REQ-016 RD_DRIVE: SHALL drive the output register onto Ram1Data; re-read mem[addr] each cycle so a changed address yields the new word one cycle later.
REQ-017 Ram1Data drive enable SHALL be the registered state==RD_DRIVE gated combinationally with Ram1EN=0, Ram1OE=0, Ram1WE=1; bus is high-Z in the same cycle any of these fails.
REQ-018 In RD_WAIT or RD_DRIVE, Ram1OE=1 or Ram1EN=1 sampled -> IDLE; Ram1WE=0 sampled -> abandon read, capture write, go WR_HOLD.
REQ-019 WR_HOLD: while EN=0 and WE=0, re-capture addr/data each cycle (last sample wins); never drive the bus.
REQ-020 WR_HOLD exit (first sample with WE=1 or EN=1) SHALL commit captured data to mem[captured addr] on that edge and update light; next state IDLE, or RD_WAIT if that same sample is a valid read.
REQ-021 OE=0 together with WE=0 while EN=0 SHALL be treated as a write and SHALL set err.
REQ-022 Address >= 2**DEPTH_LOG2: reads drive 16'h0000, writes are dropped (no memory or light update), err set.
REQ-023 Read of an address committed on the previous edge SHALL return the new data (no stale read).
REQ-024 err SHALL remain 1 until reset.

Reset
REQ-025 rst=0 at a rising edge SHALL force state IDLE, bus high-Z, light=16'h0000, err=0, counter=0.
REQ-026 Reset SHALL NOT clear memory contents; a write pending in WR_HOLD at reset SHALL be discarded.
REQ-027 Inputs SHALL be ignored during every cycle rst=0.

Structure
REQ-028 Shared package ram1_pkg SHALL hold the state enum, DATA_W=16, ADDR_W=18 and the RD_LAT limits.
REQ-029 Storage SHALL be a sub-module ram1_array (synchronous write, asynchronous or registered read, 2**DEPTH_LOG2 x 16); FSM, capture and bus logic stay in ram1_responder.

Verification
REQ-030 Write 16'h1234 to addr 5 (WE low 2 cycles, then high) -> mem[5]=16'h1234, light=16'h1234 on the commit edge; bus never driven.
REQ-031 Read addr 5 with RD_LAT=2 -> Ram1Data Z for 2 cycles, then 16'h1234 until OE rises; Z in the same cycle OE=1.
REQ-032 Write addr 7 with data changing 16'hAAAA -> 16'h5555 while WE low -> mem[7]=16'h5555.
REQ-033 Read addr 18'h3FFFF -> Ram1Data 16'h0000, err=1; following write to 18'h3FFFF leaves light unchanged.
REQ-034 OE=0, WE=0, EN=0 at addr 3, data 16'h00FF -> mem[3]=16'h00FF, bus Z, err=1.
REQ-035 rst=0 during WR_HOLD for addr 9 -> mem[9] unchanged, light=0, err=0, bus Z; earlier mem[5]=16'h1234 still readable.
